ff_and_monitor: RTL and testbench
=================================

Name: ff_and_monitor

Overview:
- Synthesizable response checker for the AND-gated D flip-flop with async clear0/preset0 and complementary outputs.
- Where a stimulus bench drives the flop, this block is the reading end: it observes the flop's inputs, async controls and outputs, models the expected output, and counts ticks, mismatches and skipped checks.
- It sits beside the flop in a self-checking harness or on-board test wrapper and exposes pass/fail and diagnostic counters.

Parameters:
- NUM_TICKS, 9: number of compared clock edges in RUN before DONE.
- ID_NUM, 20'h65166: expected value on the flop's id_num output.
- CNT_W, 16: width of tick_count and first_err_tick.
- ERR_W, 8: width of err_count and skip_count; both saturate.

Ports:
- clk  in  1  single clock; rising edge active.
- clear0  in  1  asynchronous active-low reset of this block.
- start  in  1  level; starts a run when sampled high in IDLE.
- stop  in  1  level; forces DONE from PRIME or RUN.
- ip0  in  1  flop data input 0, observed.
- ip1  in  1  flop data input 1, observed.
- dut_clear0  in  1  flop async clear, observed; active low.
- dut_preset0  in  1  flop async preset, observed; active low.
- op0  in  1  flop Q, observed.
- op0bar  in  1  flop Q-bar, observed.
- id_num  in  20  flop ID output, observed.
- state  out  2  IDLE=0, PRIME=1, RUN=2, DONE=3.
- tick_count  out  CNT_W  edges spent in RUN.
- err_count  out  ERR_W  op0 mismatches; saturates at all-ones.
- skip_count  out  ERR_W  edges where the compare was suppressed; saturates.
- first_err_tick  out  CNT_W  tick_count value at the first mismatch; all-ones if there was none.
- bar_err  out  1  sticky; set when op0bar equals op0 at a compared edge.
- id_ok  out  1  registered (id_num == ID_NUM), updated every edge.
- pass  out  1  high only in DONE with err_count==0, bar_err==0 and id_ok==1.

Behaviour:
- Reset (clear0 low, asynchronous): state=IDLE, all counters=0, first_err_tick=all-ones, bar_err=0, id_ok=0, exp_q=0, prev_async=2'b11.
- All other updates occur on the rising edge of clk. Observed inputs are sampled at that edge, so op0 is seen at its pre-edge value.
- exp_q is the model register. Every edge in PRIME or RUN: exp_q <= ip0 & ip1. The async override takes priority: dut_clear0 low gives exp_q <= 0; else dut_preset0 low gives exp_q <= 1.
- The compare at an edge uses exp_q from the previous edge against the sampled op0.
- Compare is suppressed, and skip_count increments, if either async control is low at the current edge or was low at the previous edge (prev_async).
- Both dut_clear0 and dut_preset0 low at once is also a suppressed edge.
- Async pulses that start and end strictly between two edges are not detected and will show as mismatches. The bench must hold async controls across an edge.
- When a compare is not suppressed:
  - op0 != exp_q: err_count++. If err_count was 0, first_err_tick <= tick_count.
  - op0bar == op0: bar_err <= 1.
- FSM transitions:
  - IDLE -> PRIME when start=1. Counters, bar_err and first_err_tick are cleared on this transition, so re-runs start clean.
  - PRIME: one edge that loads exp_q with no compare and no tick. -> RUN.
  - RUN: tick_count++ each edge, with a compare or skip. -> DONE when tick_count reaches NUM_TICKS-1 at this edge, i.e. after NUM_TICKS edges.
  - stop=1 in PRIME or RUN -> DONE at that edge, with no compare on that edge. stop has priority over the tick limit.
  - DONE: counters frozen; -> IDLE when start=0 and stop=0.
- Saturation: err_count and skip_count hold at 2^ERR_W-1. tick_count cannot overflow, given NUM_TICKS < 2^CNT_W, which is checked by an elaboration assertion.
- clear0 asserted mid-run: immediate return to the reset values. No partial results are retained.

Decomposition:
- Shared package ff_test_pkg holds:
  - the state encoding constants (ST_IDLE..ST_DONE);
  - the default ID_NUM constant;
  - a function sat_inc(value, width) for the saturating counters.
- One natural sub-module, ff_and_model: exp_q register plus async override and the suppress logic (prev_async). Outputs exp_q and cmp_en.
- FSM and counters stay in the top.

Test Plan:
- Reset then start, correct flop, ip0=ip1=1 for 9 edges -> DONE after 10 edges total (1 PRIME + 9 RUN), tick_count=9, err_count=0, pass=1.
- op0 stuck at 0 while ip0=ip1=1 from PRIME onward -> err_count=9, first_err_tick=0, pass=0.
- dut_clear0 low across RUN edge 3 only -> skip_count=2 (edges 3 and 4), err_count=0.
- op0bar tied to op0 -> bar_err=1 at the first compared edge, pass=0.
- stop asserted at RUN edge 4 -> DONE with tick_count=4, and state returns to IDLE once start=stop=0.
- id_num=20'h00000 -> id_ok=0 and pass=0 despite err_count=0. Also: clear0 pulsed mid-RUN -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/ff_test_pkg.sv
// Shared constants and helpers for the AND-gated flop response checker.
// State encoding, default flop ID and a saturating increment.
package ff_test_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [19:0] ID_NUM_DEF = 20'h65166;

    // Holds at 2^width-1 instead of wrapping.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] value,
        input int          width
    );
        logic [31:0] max_v;
        if (width >= 32)
            max_v = '1;
        else
            max_v = (32'd1 << width) - 32'd1;
        if (value >= max_v)
            return max_v;
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/ff_and_model.sv
// Reference model of the AND-gated D flop: expected Q register plus
// async override and compare-suppress tracking across edges.
module ff_and_model
    import ff_test_pkg::*;
(
    input  logic clk,
    input  logic clear0,
    input  logic en,
    input  logic ip0,
    input  logic ip1,
    input  logic dut_clear0,
    input  logic dut_preset0,
    output logic exp_q,
    output logic cmp_en
);

    logic [1:0] prev_async;

    always_ff @(posedge clk or negedge clear0) begin
        if (!clear0) begin
            exp_q      <= 1'b0;
            prev_async <= 2'b11;
        end else begin
            prev_async <= {dut_clear0, dut_preset0};
            if (en) begin
                if (!dut_clear0)
                    exp_q <= 1'b0;
                else if (!dut_preset0)
                    exp_q <= 1'b1;
                else
                    exp_q <= ip0 & ip1;
            end
        end
    end

    // An async control seen low now or on the last edge leaves Q unknown.
    assign cmp_en = dut_clear0 & dut_preset0 & (&prev_async);

endmodule

// File: rtl/ff_and_monitor.sv
// Response checker for the AND-gated flop: FSM, tick/error/skip
// counters and pass/fail reporting.
module ff_and_monitor
    import ff_test_pkg::*;
#(
    parameter int          NUM_TICKS = 9,
    parameter logic [19:0] ID_NUM    = ID_NUM_DEF,
    parameter int          CNT_W     = 16,
    parameter int          ERR_W     = 8
) (
    input  logic             clk,
    input  logic             clear0,
    input  logic             start,
    input  logic             stop,
    input  logic             ip0,
    input  logic             ip1,
    input  logic             dut_clear0,
    input  logic             dut_preset0,
    input  logic             op0,
    input  logic             op0bar,
    input  logic [19:0]      id_num,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] tick_count,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] skip_count,
    output logic [CNT_W-1:0] first_err_tick,
    output logic             bar_err,
    output logic             id_ok,
    output logic             pass
);

    if (NUM_TICKS < 1 || NUM_TICKS >= (1 << CNT_W)) begin : g_bad_ticks
        $error("NUM_TICKS must be in 1 .. 2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(NUM_TICKS - 1);

    logic exp_q;
    logic cmp_en;
    logic model_en;

    assign model_en = (state == ST_PRIME) || (state == ST_RUN);

    ff_and_model u_model (
        .clk         (clk),
        .clear0      (clear0),
        .en          (model_en),
        .ip0         (ip0),
        .ip1         (ip1),
        .dut_clear0  (dut_clear0),
        .dut_preset0 (dut_preset0),
        .exp_q       (exp_q),
        .cmp_en      (cmp_en)
    );

    always_ff @(posedge clk or negedge clear0) begin
        if (!clear0) begin
            state          <= ST_IDLE;
            tick_count     <= '0;
            err_count      <= '0;
            skip_count     <= '0;
            first_err_tick <= '1;
            bar_err        <= 1'b0;
            id_ok          <= 1'b0;
        end else begin
            id_ok <= (id_num == ID_NUM);
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state          <= ST_PRIME;
                        tick_count     <= '0;
                        err_count      <= '0;
                        skip_count     <= '0;
                        first_err_tick <= '1;
                        bar_err        <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    state <= stop ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_DONE;
                    end else begin
                        tick_count <= tick_count + 1'b1;
                        if (cmp_en) begin
                            if (op0 != exp_q) begin
                                err_count <= ERR_W'(sat_inc(
                                    32'(err_count), ERR_W));
                                if (err_count == '0)
                                    first_err_tick <= tick_count;
                            end
                            if (op0bar == op0)
                                bar_err <= 1'b1;
                        end else begin
                            skip_count <= ERR_W'(sat_inc(
                                32'(skip_count), ERR_W));
                        end
                        if (tick_count == LAST_TICK)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!start && !stop)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pass = (state == ST_DONE) && (err_count == '0)
                  && !bar_err && id_ok;

endmodule

// File: tb/tb_ff_and_monitor.sv
// Directed bench for ff_and_monitor with a behavioural AND-gated flop
// that can be forced stuck or have its complementary output tied.
module tb_ff_and_monitor;
    import ff_test_pkg::*;

    logic clktb = 1'b0;
    always #5 clktb = ~clktb;

    logic        clear0;
    logic        start;
    logic        stop;
    logic        ip0;
    logic        ip1;
    logic        dut_clear0;
    logic        dut_preset0;
    logic        op0;
    logic        op0bar;
    logic [19:0] id_num;
    logic [1:0]  state;
    logic [15:0] tick_count;
    logic [7:0]  err_count;
    logic [7:0]  skip_count;
    logic [15:0] first_err_tick;
    logic        bar_err;
    logic        id_ok;
    logic        pass;

    logic fq      = 1'b0;
    logic stuck   = 1'b0;
    logic bar_tie = 1'b0;

    int checks   = 0;
    int failures = 0;

    always @(posedge clktb or negedge dut_clear0 or negedge dut_preset0) begin
        if (!dut_clear0)
            fq <= 1'b0;
        else if (!dut_preset0)
            fq <= 1'b1;
        else
            fq <= ip0 & ip1;
    end

    assign op0    = stuck ? 1'b0 : fq;
    assign op0bar = bar_tie ? op0 : ~op0;

    ff_and_monitor dut (
        .clk            (clktb),
        .clear0         (clear0),
        .start          (start),
        .stop           (stop),
        .ip0            (ip0),
        .ip1            (ip1),
        .dut_clear0     (dut_clear0),
        .dut_preset0    (dut_preset0),
        .op0            (op0),
        .op0bar         (op0bar),
        .id_num         (id_num),
        .state          (state),
        .tick_count     (tick_count),
        .err_count      (err_count),
        .skip_count     (skip_count),
        .first_err_tick (first_err_tick),
        .bar_err        (bar_err),
        .id_ok          (id_ok),
        .pass           (pass)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clktb);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        clear0 = 1'b0; start = 1'b0; stop = 1'b0;
        ip0 = 1'b1; ip1 = 1'b1;
        dut_clear0 = 1'b1; dut_preset0 = 1'b1;
        id_num = 20'h65166;
        tick(2);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (tick_count !== 16'd0) begin failures++; $display("FAIL rst_tick got=%0d exp=0", tick_count); end
        checks++; if (err_count !== 8'd0 || skip_count !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", err_count, skip_count); end
        checks++; if (first_err_tick !== 16'hFFFF) begin failures++; $display("FAIL rst_first got=%0h exp=ffff", first_err_tick); end
        checks++; if ({bar_err, id_ok, pass} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {bar_err, id_ok, pass}); end
        clear0 = 1'b1;
        tick(1);
        checks++; if (id_ok !== 1'b1) begin failures++; $display("FAIL rst_idok got=%b exp=1", id_ok); end
    endtask

    task automatic test_clean();
        do_start();
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL clean_prime got=%0d exp=1", state); end
        tick(1);
        checks++; if (state !== 2'd2 || tick_count !== 16'd0) begin failures++; $display("FAIL clean_run0 got=%0d/%0d exp=2/0", state, tick_count); end
        tick(8);
        checks++; if (state !== 2'd2 || tick_count !== 16'd8) begin failures++; $display("FAIL clean_run8 got=%0d/%0d exp=2/8", state, tick_count); end
        tick(1);
        checks++; if (state !== 2'd3 || tick_count !== 16'd9) begin failures++; $display("FAIL clean_done got=%0d/%0d exp=3/9", state, tick_count); end
        checks++; if (err_count !== 8'd0 || skip_count !== 8'd0) begin failures++; $display("FAIL clean_cnt got=%0d/%0d exp=0/0", err_count, skip_count); end
        checks++; if (first_err_tick !== 16'hFFFF) begin failures++; $display("FAIL clean_first got=%0h exp=ffff", first_err_tick); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL clean_pass got=%b exp=1", pass); end
        tick(1);
        checks++; if (state !== 2'd0 || pass !== 1'b0) begin failures++; $display("FAIL clean_idle got=%0d/%b exp=0/0", state, pass); end
    endtask

    task automatic test_stuck();
        stuck = 1'b1;
        do_start();
        tick(10);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL stuck_state got=%0d exp=3", state); end
        checks++; if (err_count !== 8'd9) begin failures++; $display("FAIL stuck_err got=%0d exp=9", err_count); end
        checks++; if (first_err_tick !== 16'd0) begin failures++; $display("FAIL stuck_first got=%0h exp=0", first_err_tick); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL stuck_pass got=%b exp=0", pass); end
        stuck = 1'b0;
        tick(1);
    endtask

    task automatic test_async_skip();
        do_start();
        tick(1);
        checks++; if (err_count !== 8'd0 || first_err_tick !== 16'hFFFF) begin failures++; $display("FAIL skip_rerun got=%0d/%0h exp=0/ffff", err_count, first_err_tick); end
        tick(3);
        checks++; if (tick_count !== 16'd3) begin failures++; $display("FAIL skip_tick3 got=%0d exp=3", tick_count); end
        dut_clear0 = 1'b0;
        tick(1);
        dut_clear0 = 1'b1;
        checks++; if (skip_count !== 8'd1) begin failures++; $display("FAIL skip_edge3 got=%0d exp=1", skip_count); end
        tick(5);
        checks++; if (state !== 2'd3 || tick_count !== 16'd9) begin failures++; $display("FAIL skip_done got=%0d/%0d exp=3/9", state, tick_count); end
        checks++; if (skip_count !== 8'd2) begin failures++; $display("FAIL skip_cnt got=%0d exp=2", skip_count); end
        checks++; if (err_count !== 8'd0 || pass !== 1'b1) begin failures++; $display("FAIL skip_err got=%0d/%b exp=0/1", err_count, pass); end
        tick(1);
    endtask

    task automatic test_bar();
        bar_tie = 1'b1;
        do_start();
        tick(1);
        checks++; if (bar_err !== 1'b0) begin failures++; $display("FAIL bar_prime got=%b exp=0", bar_err); end
        tick(1);
        checks++; if (bar_err !== 1'b1) begin failures++; $display("FAIL bar_first got=%b exp=1", bar_err); end
        tick(8);
        checks++; if (state !== 2'd3 || err_count !== 8'd0) begin failures++; $display("FAIL bar_done got=%0d/%0d exp=3/0", state, err_count); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL bar_pass got=%b exp=0", pass); end
        bar_tie = 1'b0;
        tick(1);
    endtask

    task automatic test_stop();
        do_start();
        tick(1);
        checks++; if (bar_err !== 1'b0) begin failures++; $display("FAIL stop_barclr got=%b exp=0", bar_err); end
        tick(4);
        stop = 1'b1;
        tick(1);
        checks++; if (state !== 2'd3 || tick_count !== 16'd4) begin failures++; $display("FAIL stop_done got=%0d/%0d exp=3/4", state, tick_count); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL stop_pass got=%b exp=1", pass); end
        tick(1);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL stop_hold got=%0d exp=3", state); end
        stop = 1'b0;
        tick(1);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL stop_idle got=%0d exp=0", state); end
    endtask

    task automatic test_id();
        id_num = 20'h00000;
        do_start();
        tick(10);
        checks++; if (state !== 2'd3 || err_count !== 8'd0) begin failures++; $display("FAIL id_done got=%0d/%0d exp=3/0", state, err_count); end
        checks++; if (id_ok !== 1'b0) begin failures++; $display("FAIL id_ok got=%b exp=0", id_ok); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL id_pass got=%b exp=0", pass); end
        id_num = 20'h65166;
        tick(1);
        checks++; if (id_ok !== 1'b1) begin failures++; $display("FAIL id_restore got=%b exp=1", id_ok); end
    endtask

    task automatic test_clear_mid();
        stuck = 1'b1;
        do_start();
        tick(4);
        checks++; if (tick_count !== 16'd3 || err_count !== 8'd3) begin failures++; $display("FAIL clr_pre got=%0d/%0d exp=3/3", tick_count, err_count); end
        #2 clear0 = 1'b0;
        #1;
        checks++; if (state !== 2'd0 || tick_count !== 16'd0) begin failures++; $display("FAIL clr_state got=%0d/%0d exp=0/0", state, tick_count); end
        checks++; if (err_count !== 8'd0 || skip_count !== 8'd0) begin failures++; $display("FAIL clr_cnt got=%0d/%0d exp=0/0", err_count, skip_count); end
        checks++; if (first_err_tick !== 16'hFFFF) begin failures++; $display("FAIL clr_first got=%0h exp=ffff", first_err_tick); end
        checks++; if ({bar_err, id_ok, pass} !== 3'b000) begin failures++; $display("FAIL clr_flags got=%b exp=000", {bar_err, id_ok, pass}); end
        @(negedge clktb);
        clear0 = 1'b1;
        stuck = 1'b0;
        tick(1);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL clr_after got=%0d exp=0", state); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_stuck();
        test_async_skip();
        test_bar();
        test_stop();
        test_id();
        test_clear_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
